// File: rtl/prt_scaler_krnl_tap.sv
// Kernel tap generator: builds a 2-line x 5-pixel sliding window from a stream of
// pixel pairs, replicating the first pixel on load and the last pixel during the flush.
module prt_scaler_krnl_tap #(
    parameter int P_BPC = 8
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic             DAT_VLD_IN,
    output logic             DAT_RDY_OUT,
    input  logic             DAT_SOL_IN,
    input  logic             DAT_EOL_IN,
    input  logic [P_BPC-1:0] DAT0_IN,
    input  logic [P_BPC-1:0] DAT1_IN,
    output logic [P_BPC-1:0] A_DAT_OUT,
    output logic [P_BPC-1:0] B_DAT_OUT,
    output logic [P_BPC-1:0] C_DAT_OUT,
    output logic [P_BPC-1:0] D_DAT_OUT,
    output logic [P_BPC-1:0] E_DAT_OUT,
    output logic [P_BPC-1:0] F_DAT_OUT,
    output logic [P_BPC-1:0] G_DAT_OUT,
    output logic [P_BPC-1:0] H_DAT_OUT,
    output logic [P_BPC-1:0] I_DAT_OUT,
    output logic [P_BPC-1:0] J_DAT_OUT,
    output logic             TAP_VLD_OUT,
    output logic             TAP_SOL_OUT,
    output logic             TAP_EOL_OUT,
    output logic [1:0]       DBG_STATE_OUT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH1 = 2'd2,
        FLUSH2 = 2'd3
    } state_t;

    // Handshake: a pixel pair transfers on a rising edge where DAT_VLD_IN and
    // DAT_RDY_OUT are both high; DAT_RDY_OUT never depends on DAT_VLD_IN.
    state_t state, state_nxt;
    logic                  rdy_q;
    logic                  xfer;
    logic                  do_load;
    logic                  do_shift;
    logic [P_BPC-1:0]      shift_in0;
    logic [P_BPC-1:0]      shift_in1;
    logic [1:0]            cnt_q;
    // Index 0 is the oldest pixel (A/F), index 4 the newest (E/J).
    logic [4:0][P_BPC-1:0] line0_q;
    logic [4:0][P_BPC-1:0] line1_q;
    logic                  vld_q;
    logic                  sol_q;
    logic                  eol_q;

    assign xfer = DAT_VLD_IN & rdy_q;

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        shift_in0 = DAT0_IN;
        shift_in1 = DAT1_IN;
        case (state)
            IDLE: begin
                if (xfer && DAT_SOL_IN) begin
                    do_load   = 1'b1;
                    state_nxt = DAT_EOL_IN ? FLUSH1 : RUN;
                end
            end
            RUN: begin
                // SOL without a preceding EOL aborts the current line with no flush.
                if (xfer) begin
                    do_load   = DAT_SOL_IN;
                    do_shift  = ~DAT_SOL_IN;
                    state_nxt = DAT_EOL_IN ? FLUSH1 : RUN;
                end
            end
            FLUSH1: begin
                do_shift  = 1'b1;
                shift_in0 = line0_q[4];
                shift_in1 = line1_q[4];
                state_nxt = FLUSH2;
            end
            FLUSH2: begin
                do_shift  = 1'b1;
                shift_in0 = line0_q[4];
                shift_in1 = line1_q[4];
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state   <= IDLE;
            rdy_q   <= 1'b1;
            cnt_q   <= 2'd0;
            line0_q <= '0;
            line1_q <= '0;
            vld_q   <= 1'b0;
            sol_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt == IDLE) || (state_nxt == RUN);
            vld_q <= do_shift && (cnt_q != 2'd0);
            sol_q <= do_shift && (cnt_q == 2'd1);
            eol_q <= do_shift && (cnt_q != 2'd0) && (state == FLUSH2);
            if (do_load) begin
                line0_q <= {5{DAT0_IN}};
                line1_q <= {5{DAT1_IN}};
                cnt_q   <= 2'd0;
            end else if (do_shift) begin
                line0_q <= {shift_in0, line0_q[4:1]};
                line1_q <= {shift_in1, line1_q[4:1]};
                cnt_q   <= (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
            end
        end
    end

    assign DAT_RDY_OUT   = rdy_q;
    assign A_DAT_OUT     = line0_q[0];
    assign B_DAT_OUT     = line0_q[1];
    assign C_DAT_OUT     = line0_q[2];
    assign D_DAT_OUT     = line0_q[3];
    assign E_DAT_OUT     = line0_q[4];
    assign F_DAT_OUT     = line1_q[0];
    assign G_DAT_OUT     = line1_q[1];
    assign H_DAT_OUT     = line1_q[2];
    assign I_DAT_OUT     = line1_q[3];
    assign J_DAT_OUT     = line1_q[4];
    assign TAP_VLD_OUT   = vld_q;
    assign TAP_SOL_OUT   = sol_q;
    assign TAP_EOL_OUT   = eol_q;
    assign DBG_STATE_OUT = state;

endmodule

// File: tb/tb_prt_scaler_krnl_tap.sv
// Directed bench for prt_scaler_krnl_tap: stimulus pushes hand-computed windows,
// an independent monitor pops and compares on every TAP_VLD_OUT strobe.
module tb_prt_scaler_krnl_tap;

  localparam int BPC = 8;
  localparam int W   = 10 * BPC + 2;

  logic           clk_in;
  logic           rst_in;
  logic           dat_vld_in;
  logic           dat_rdy_out;
  logic           dat_sol_in;
  logic           dat_eol_in;
  logic [BPC-1:0] dat0_in;
  logic [BPC-1:0] dat1_in;
  logic [BPC-1:0] a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o, i_o, j_o;
  logic           tap_vld_out;
  logic           tap_sol_out;
  logic           tap_eol_out;
  logic [1:0]     dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  prt_scaler_krnl_tap #(.P_BPC(BPC)) dut (
    .CLK_IN(clk_in),
    .RST_IN(rst_in),
    .DAT_VLD_IN(dat_vld_in),
    .DAT_RDY_OUT(dat_rdy_out),
    .DAT_SOL_IN(dat_sol_in),
    .DAT_EOL_IN(dat_eol_in),
    .DAT0_IN(dat0_in),
    .DAT1_IN(dat1_in),
    .A_DAT_OUT(a_o),
    .B_DAT_OUT(b_o),
    .C_DAT_OUT(c_o),
    .D_DAT_OUT(d_o),
    .E_DAT_OUT(e_o),
    .F_DAT_OUT(f_o),
    .G_DAT_OUT(g_o),
    .H_DAT_OUT(h_o),
    .I_DAT_OUT(i_o),
    .J_DAT_OUT(j_o),
    .TAP_VLD_OUT(tap_vld_out),
    .TAP_SOL_OUT(tap_sol_out),
    .TAP_EOL_OUT(tap_eol_out),
    .DBG_STATE_OUT(dbg_state)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [W-1:0] win(input logic [7:0] a, b, c, d, e,
                                       input logic [7:0] off, input logic s, input logic eo);
    logic [7:0] fa, fb, fc, fd, fe;
    fa = a + off; fb = b + off; fc = c + off; fd = d + off; fe = e + off;
    return {a, b, c, d, e, fa, fb, fc, fd, fe, s, eo};
  endfunction

  function automatic logic [W-1:0] act_win();
    return {a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o, i_o, j_o, tap_sol_out, tap_eol_out};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && tap_vld_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", act_win(), '0);
      end else begin
        check("window", act_win(), exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] d0, input logic [7:0] d1, input logic sol, input logic eol);
    int t = 0;
    dat_vld_in = 1'b1;
    dat0_in    = d0;
    dat1_in    = d1;
    dat_sol_in = sol;
    dat_eol_in = eol;
    @(negedge clk_in);
    while (dat_rdy_out !== 1'b1 && t < 20) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 20) check("rdy_timeout", W'(dat_rdy_out), W'(1));
    @(posedge clk_in);
    #1;
    dat_vld_in = 1'b0;
    dat_sol_in = 1'b0;
    dat_eol_in = 1'b0;
  endtask

  task automatic idle(input int n);
    dat_vld_in = 1'b0;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk_in);
      t++;
    end
    if (exp_q.size() != 0) begin
      check(name, W'(exp_q.size()), '0);
      exp_q.delete();
    end
    idle(4);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {act_win(), W'({tap_vld_out, dat_rdy_out, dbg_state})},
          {{W{1'b0}}, W'({1'b0, 1'b1, 2'd0})});
  endtask

  initial begin
    rst_in     = 1'b0;
    dat_vld_in = 1'b0;
    dat_sol_in = 1'b0;
    dat_eol_in = 1'b0;
    dat0_in    = '0;
    dat1_in    = '0;
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset_state");
    rst_in = 1'b1;
    idle(2);

    // N=5, continuous valid, plus ready drop during the flush
    exp_q.push_back(win(10, 10, 10, 11, 12, 10, 1'b1, 1'b0));
    exp_q.push_back(win(10, 10, 11, 12, 13, 10, 1'b0, 1'b0));
    exp_q.push_back(win(10, 11, 12, 13, 14, 10, 1'b0, 1'b0));
    exp_q.push_back(win(11, 12, 13, 14, 14, 10, 1'b0, 1'b0));
    exp_q.push_back(win(12, 13, 14, 14, 14, 10, 1'b0, 1'b1));
    send(10, 20, 1'b1, 1'b0);
    send(11, 21, 1'b0, 1'b0);
    send(12, 22, 1'b0, 1'b0);
    send(13, 23, 1'b0, 1'b0);
    send(14, 24, 1'b0, 1'b1);
    @(negedge clk_in);
    check("rdy_flush1", W'(dat_rdy_out), W'(0));
    @(negedge clk_in);
    check("rdy_flush2", W'(dat_rdy_out), W'(0));
    @(negedge clk_in);
    check("rdy_idle", W'(dat_rdy_out), W'(1));
    drain("drain_n5");

    // N=1
    exp_q.push_back(win(7, 7, 7, 7, 7, 10, 1'b1, 1'b1));
    send(7, 17, 1'b1, 1'b1);
    drain("drain_n1");

    // N=2
    exp_q.push_back(win(3, 3, 3, 4, 4, 10, 1'b1, 1'b0));
    exp_q.push_back(win(3, 3, 4, 4, 4, 10, 1'b0, 1'b1));
    send(3, 13, 1'b1, 1'b0);
    send(4, 14, 1'b0, 1'b1);
    drain("drain_n2");

    // N=5 with valid toggling every other cycle
    exp_q.push_back(win(10, 10, 10, 11, 12, 10, 1'b1, 1'b0));
    exp_q.push_back(win(10, 10, 11, 12, 13, 10, 1'b0, 1'b0));
    exp_q.push_back(win(10, 11, 12, 13, 14, 10, 1'b0, 1'b0));
    exp_q.push_back(win(11, 12, 13, 14, 14, 10, 1'b0, 1'b0));
    exp_q.push_back(win(12, 13, 14, 14, 14, 10, 1'b0, 1'b1));
    for (int k = 0; k < 5; k++) begin
      send(8'(10 + k), 8'(20 + k), k == 0, k == 4);
      if (k != 4) idle(1);
    end
    drain("drain_toggle");

    // aborted line followed by a 3-pixel line of 9s
    exp_q.push_back(win(1, 1, 1, 2, 3, 100, 1'b1, 1'b0));
    exp_q.push_back(win(9, 9, 9, 9, 9, 10, 1'b1, 1'b0));
    exp_q.push_back(win(9, 9, 9, 9, 9, 10, 1'b0, 1'b0));
    exp_q.push_back(win(9, 9, 9, 9, 9, 10, 1'b0, 1'b1));
    send(1, 101, 1'b1, 1'b0);
    send(2, 102, 1'b0, 1'b0);
    send(3, 103, 1'b0, 1'b0);
    send(9, 19, 1'b1, 1'b0);
    send(9, 19, 1'b0, 1'b0);
    send(9, 19, 1'b0, 1'b1);
    drain("drain_abort");

    // reset pulse during FLUSH1, then a fresh 3-pixel line
    send(50, 60, 1'b1, 1'b1);
    check("state_flush1", W'(dbg_state), W'(2));
    rst_in = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    @(negedge clk_in);
    check_reset_outputs("reset_held");
    rst_in = 1'b1;
    idle(5);
    exp_q.push_back(win(1, 1, 1, 2, 3, 4, 1'b1, 1'b0));
    exp_q.push_back(win(1, 1, 2, 3, 3, 4, 1'b0, 1'b0));
    exp_q.push_back(win(1, 2, 3, 3, 3, 4, 1'b0, 1'b1));
    send(1, 5, 1'b1, 1'b0);
    send(2, 6, 1'b0, 1'b0);
    send(3, 7, 1'b0, 1'b1);
    drain("drain_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
